note_player: RTL and testbench
==============================

# note_player

Downstream consumer of `song_reader`: accepts one note/duration pair per `new_note` pulse. Looks up the note's phase-increment in a frequency ROM and drives it on `step_size` to the sine-sample generator for the requested number of beats. Signals completion back to `song_reader` with a one-cycle `note_done` pulse. Pausing (`play` low) freezes the beat count and mutes the output.

## Interface
Parameters:
- `NOTE_W`, 6: note code width; code 0 is a rest.
- `DUR_W`, 6: duration width, in beats.
- `STEP_W`, 20: phase-increment width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `play`  in  1  level; low pauses playback.
- `beat`  in  1  one-cycle pulse per beat, from the beat generator.
- `note`  in  NOTE_W  note code, valid with `new_note`.
- `duration`  in  DUR_W  beats, valid with `new_note`.
- `new_note`  in  1  one-cycle load strobe from `song_reader`.
- `note_done`  out  1  one-cycle pulse when the current note completes.
- `step_size`  out  STEP_W  phase increment; 0 means silence.
- `playing`  out  1  high while a note is loaded or sounding (LOAD or PLAY).

## Operation
- States: IDLE, LOAD, PLAY, DONE.
- **Reset:** forces IDLE; `step_reg`=0, `beats_left`=0, `note_done`=0, `playing`=0. Reset mid-note abandons the note with no `note_done`.
- **IDLE:**
  - `new_note`=1 → latch `duration` into `beats_left`, present `note` as the ROM address, go to LOAD. The load occurs regardless of `play`.
  - `new_note`=0 → stay.
- **LOAD** (one cycle, waits for the synchronous ROM):
  - `step_reg` ← ROM data, or 0 if the latched note is 0 (rest).
  - Latched duration == 0 → go to DONE with `step_reg` ← 0. A zero-length note still completes with a `note_done` pulse.
  - Otherwise → go to PLAY.
- **PLAY:**
  - `beat`=1 and `play`=1: decrement `beats_left`. When decrementing from 1, go to DONE and clear `step_reg` in the same edge.
  - `beat` while `play`=0 is dropped; it is neither counted nor queued.
- **DONE:** `note_done`=1 for exactly this cycle, then go to IDLE.
- `new_note` outside IDLE is ignored; `song_reader` never issues one before `note_done`.
- `beat` in IDLE, LOAD or DONE is not counted, including when `beat` coincides with `new_note`.
- Output: `step_size` = `play` ? `step_reg` : 0. This is the only combinational path; all other outputs come straight from registers or state decode.
- Widths: `beats_left` is DUR_W bits and never underflows. The maximum duration, 63, yields exactly 63 counted beats.

## Timing
- Edge T0 samples `new_note`. LOAD during T0→T1. `step_size` is valid after edge T1 (2-cycle load latency).
- Duration d ≥ 1: the d-th qualifying beat is sampled at edge Tk.
  - `step_size` is 0 after Tk.
  - `note_done` is high during Tk→Tk+1.
  - IDLE after Tk+1; a `new_note` sampled at Tk+1 is accepted.
- Duration 0: `note_done` is high during T1→T2; `step_size` stays 0 throughout.
- `playing` is high exactly from after T0 until Tk (PLAY exit).

## Structure
- Shared package `music_pkg` holds:
  - NOTE_W, DUR_W, STEP_W.
  - REST_NOTE = 0.
  - The state enum {IDLE, LOAD, PLAY, DONE}.
- Sub-module `frequency_rom`: 64 × STEP_W synchronous ROM, 1-cycle read latency, ports `clk`, `addr`, `dout`. Entry 0 is 0.
- `note_player` itself contains only the FSM, the beat down-counter and the output mux.

## Test plan
- **Reset values:** hold `reset` 2 cycles, then release → `note_done`=0, `playing`=0, `step_size`=0.
- **Basic note:** `new_note` with note=12, duration=3, `play`=1, `beat` every 8 cycles.
  - `step_size` == ROM[12] two edges after the load.
  - `note_done` pulses exactly once, the cycle after the 3rd beat.
  - `step_size` == 0 in that cycle.
- **Rest and zero-duration:**
  - note=0, duration=2 → `step_size` stays 0; `note_done` after the 2nd beat.
  - note=5, duration=0 → `note_done` two cycles after `new_note`, with no beats needed.
- **Pause:** note=20, duration=4; drop `play` after beat 1, pulse `beat` 3 times, raise `play`.
  - `step_size`=0 while paused; no `note_done` during the pause.
  - `note_done` arrives after 3 further beats.
- **Back-to-back and ignored strobes:**
  - A `new_note` pulsed mid-PLAY is ignored.
  - A `new_note` on the cycle after `note_done` is accepted.
  - Drive `song_reader` + `song_rom` song 1 end-to-end → every note's `step_size` == ROM[note]; `song_done` is reached.
- **Reset mid-note:** assert `reset` during PLAY with `beats_left`=5 → IDLE the next cycle, `step_size`=0, no `note_done` pulse.

Source files
------------

// File: rtl/music_pkg.sv
// Shared widths, state encoding and note-to-phase-increment table
// for the note player and its frequency ROM.
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int STEP_W = 20;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } state_t;

    // Phase increment for a 20-bit accumulator at 48 kHz.
    // Note 1 is A1 (55 Hz); each group of 12 codes is one octave,
    // so the base semitone value is doubled once per octave.
    function automatic logic [STEP_W-1:0] note_step(
        input logic [NOTE_W-1:0] n
    );
        logic [NOTE_W-1:0] k;
        logic [2:0]        oct;
        logic [3:0]        semi;
        logic [STEP_W-1:0] base;
        k    = n - NOTE_W'(1);
        oct  = 3'(k / NOTE_W'(12));
        semi = 4'(k % NOTE_W'(12));
        unique case (semi)
            4'd0:    base = STEP_W'(1201);
            4'd1:    base = STEP_W'(1273);
            4'd2:    base = STEP_W'(1349);
            4'd3:    base = STEP_W'(1429);
            4'd4:    base = STEP_W'(1514);
            4'd5:    base = STEP_W'(1604);
            4'd6:    base = STEP_W'(1699);
            4'd7:    base = STEP_W'(1800);
            4'd8:    base = STEP_W'(1907);
            4'd9:    base = STEP_W'(2021);
            4'd10:   base = STEP_W'(2141);
            default: base = STEP_W'(2268);
        endcase
        if (n == REST_NOTE)
            return '0;
        return base << oct;
    endfunction

endpackage

// File: rtl/frequency_rom.sv
// 64-entry synchronous phase-increment ROM, one cycle read latency.
// Ports: clk; addr = note code; dout = phase increment (entry 0 is 0).
module frequency_rom
    import music_pkg::*;
(
    input  logic              clk,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= note_step(addr);
    end

endmodule

// File: rtl/note_player.sv
// Plays one note for a number of beats, then pulses note_done.
// Ports: clk, reset (sync, high), play, beat, note/duration/new_note
// load; note_done pulse, step_size (muted when paused), playing.
module note_player #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int STEP_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              new_note,
    output logic              note_done,
    output logic [STEP_W-1:0] step_size,
    output logic              playing
);
    import music_pkg::*;

    state_t state;
    state_t state_nx;

    logic [DUR_W-1:0]  beats_left;
    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] rom_dout;
    logic              is_rest;
    logic              count_beat;
    logic              last_beat;

    // The ROM samples the live note input, so its data is ready
    // during LOAD for the note strobed in IDLE.
    frequency_rom u_rom (
        .clk  (clk),
        .addr (note),
        .dout (rom_dout)
    );

    // Beats only count while sounding and unpaused; paused beats
    // are dropped rather than queued.
    assign count_beat = (state == PLAY) && beat && play;
    assign last_beat  = count_beat && (beats_left == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (new_note) state_nx = LOAD;
            LOAD: state_nx = (beats_left == '0) ? DONE : PLAY;
            PLAY: if (last_beat) state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beats_left <= '0;
            step_reg   <= '0;
            is_rest    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (new_note) begin
                        beats_left <= duration;
                        is_rest    <= (note == REST_NOTE);
                    end
                end
                LOAD: begin
                    // A zero-length note completes silently.
                    if (is_rest || beats_left == '0)
                        step_reg <= '0;
                    else
                        step_reg <= rom_dout;
                end
                PLAY: begin
                    if (count_beat) begin
                        beats_left <= beats_left - DUR_W'(1);
                        if (last_beat)
                            step_reg <= '0;
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign note_done = (state == DONE);
    assign playing   = (state == LOAD) || (state == PLAY);
    assign step_size = play ? step_reg : '0;

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player.
// Expected phase increments are hand-computed table constants.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        beat;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        note_done;
    logic [19:0] step_size;
    logic        playing;

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int d0;

    note_player dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .beat      (beat),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .note_done (note_done),
        .step_size (step_size),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (note_done === 1'b1)
            done_count <= done_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] n, input logic [5:0] d);
        note     = n;
        duration = d;
        new_note = 1'b1;
        tick();
        new_note = 1'b0;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    logic [5:0]  song_n [3] = '{6'd1, 6'd63, 6'd24};
    logic [5:0]  song_d [3] = '{6'd1, 6'd2, 6'd1};
    logic [31:0] song_s [3] = '{32'd1201, 32'd43168, 32'd4536};

    initial begin
        reset    = 1'b1;
        play     = 1'b1;
        beat     = 1'b0;
        note     = '0;
        duration = '0;
        new_note = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();
        chk("rst_done", 32'(note_done), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_step", 32'(step_size), 0);

        // Basic note 12 for 3 beats, one beat every 8 cycles.
        d0 = done_count;
        load(6'd12, 6'd3);
        chk("basic_load_playing", 32'(playing), 1);
        chk("basic_load_step", 32'(step_size), 0);
        tick();
        chk("basic_step", 32'(step_size), 2268);
        for (int i = 1; i <= 3; i++) begin
            ticks(7);
            pulse_beat();
            if (i < 3) begin
                chk("basic_mid_done", 32'(note_done), 0);
                chk("basic_mid_step", 32'(step_size), 2268);
            end
        end
        chk("basic_done", 32'(note_done), 1);
        chk("basic_done_step", 32'(step_size), 0);
        chk("basic_done_playing", 32'(playing), 0);
        tick();
        chk("basic_after_done", 32'(note_done), 0);
        chk("basic_once", 32'(done_count - d0), 1);

        // Rest note issued the cycle after note_done.
        load(6'd0, 6'd2);
        chk("rest_accepted", 32'(playing), 1);
        tick();
        chk("rest_step", 32'(step_size), 0);
        pulse_beat();
        chk("rest_b1_done", 32'(note_done), 0);
        chk("rest_b1_step", 32'(step_size), 0);
        pulse_beat();
        chk("rest_done", 32'(note_done), 1);
        tick();

        // Zero-length note completes with no beats.
        load(6'd5, 6'd0);
        chk("zero_t0_done", 32'(note_done), 0);
        chk("zero_t0_step", 32'(step_size), 0);
        tick();
        chk("zero_done", 32'(note_done), 1);
        chk("zero_step", 32'(step_size), 0);
        chk("zero_playing", 32'(playing), 0);
        tick();
        chk("zero_after", 32'(note_done), 0);

        // Pause; beat with new_note and a mid-PLAY strobe ignored.
        beat = 1'b1;
        load(6'd20, 6'd4);
        beat = 1'b0;
        tick();
        chk("pause_step", 32'(step_size), 3600);
        note     = 6'd12;
        duration = 6'd1;
        new_note = 1'b1;
        tick();
        new_note = 1'b0;
        chk("ignored_strobe_step", 32'(step_size), 3600);
        pulse_beat();
        chk("pause_b1_done", 32'(note_done), 0);
        play = 1'b0;
        tick();
        chk("paused_step", 32'(step_size), 0);
        for (int i = 0; i < 3; i++) begin
            pulse_beat();
            chk("paused_done", 32'(note_done), 0);
            chk("paused_mute", 32'(step_size), 0);
        end
        play = 1'b1;
        tick();
        chk("resume_step", 32'(step_size), 3600);
        for (int i = 1; i <= 3; i++) begin
            pulse_beat();
            if (i < 3)
                chk("resume_mid_done", 32'(note_done), 0);
        end
        chk("resume_done", 32'(note_done), 1);
        tick();

        // Maximum duration counts exactly 63 beats.
        load(6'd63, 6'd63);
        tick();
        chk("max_step", 32'(step_size), 43168);
        beat = 1'b1;
        ticks(62);
        chk("max_62_done", 32'(note_done), 0);
        chk("max_62_playing", 32'(playing), 1);
        tick();
        beat = 1'b0;
        chk("max_63_done", 32'(note_done), 1);
        tick();

        // Song-reader style back-to-back sequence.
        d0 = done_count;
        for (int s = 0; s < 3; s++) begin
            load(song_n[s], song_d[s]);
            tick();
            chk("song_step", 32'(step_size), song_s[s]);
            for (int b = 0; b < int'(song_d[s]); b++) begin
                ticks(3);
                pulse_beat();
            end
            chk("song_note_done", 32'(note_done), 1);
            tick();
        end
        chk("song_all_done", 32'(done_count - d0), 3);

        // Reset mid-note with five beats left.
        load(6'd12, 6'd6);
        tick();
        pulse_beat();
        chk("midrst_step_before", 32'(step_size), 2268);
        d0 = done_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_playing", 32'(playing), 0);
        chk("midrst_step", 32'(step_size), 0);
        chk("midrst_done", 32'(note_done), 0);
        ticks(2);
        chk("midrst_no_pulse", 32'(done_count - d0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
